// File: rtl/cla_pkg.sv
// ============================================================================
// cla_pkg : shared types and constants for the serial CLA adder controller
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package cla_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic bit width_ok(input int w);
    return (w >= 8) && ((w % NIBBLE_W) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cla4bit.sv
// ============================================================================
// cla4bit : 4-bit carry-lookahead adder slice
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module cla4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] s_o,
  output logic       cout_o
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [3:0] w_c;

  assign w_g = a_i & b_i;
  assign w_p = a_i ^ b_i;

  assign w_c[0] = cin_i;
  assign w_c[1] = w_g[0] | (w_p[0] & cin_i);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin_i);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin_i);
  assign cout_o = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin_i);

  assign s_o = w_p ^ w_c;

endmodule

`default_nettype wire

// File: rtl/cla_serial_add_ctrl.sv
// ============================================================================
// cla_serial_add_ctrl : WIDTH-bit adder built from one shared 4-bit CLA slice,
// one nibble per cycle. Optional subtract mode: define CLA_SERIAL_SUB_EN.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module cla_serial_add_ctrl
  import cla_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NSLICE = WIDTH / NIBBLE_W;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

  generate
    if (!width_ok(WIDTH)) begin : g_width_check
      $error("cla_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 8");
    end
  endgenerate

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, sum_sh_q, sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q, cout_q, in_ready_q, out_valid_q, busy_q;
  logic             sub_q;
  logic             w_req_sub;

`ifdef CLA_SERIAL_SUB_EN
  assign w_req_sub = sub;
`else
  assign w_req_sub = 1'b0;
  assign sub_q     = 1'b0;
`endif

  logic [3:0]       w_b_nib, w_slice_s;
  logic             w_slice_c;
  logic [WIDTH-1:0] sum_sh_d;

  // Subtraction is a + ~b + 1: invert each b nibble, carry seeded at accept.
  assign w_b_nib = b_sh_q[3:0] ^ {4{sub_q}};

  cla4bit u_slice (
    .a_i    (a_sh_q[3:0]),
    .b_i    (w_b_nib),
    .cin_i  (carry_q),
    .s_o    (w_slice_s),
    .cout_o (w_slice_c)
  );

  assign sum_sh_d = {w_slice_s, sum_sh_q[WIDTH-1:NIBBLE_W]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef CLA_SERIAL_SUB_EN
      sub_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_sh_q     <= a;
            b_sh_q     <= b;
            carry_q    <= w_req_sub ? 1'b1 : cin;
`ifdef CLA_SERIAL_SUB_EN
            sub_q      <= w_req_sub;
`endif
            cnt_q      <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          a_sh_q   <= a_sh_q >> NIBBLE_W;
          b_sh_q   <= b_sh_q >> NIBBLE_W;
          sum_sh_q <= sum_sh_d;
          carry_q  <= w_slice_c;
          cnt_q    <= cnt_q + CNT_W'(1);
          // Visible result changes only here, once every nibble is in place.
          if (cnt_q == LAST_CNT) begin
            sum_q       <= sum_sh_d;
            cout_q      <= w_slice_c;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_cla_serial_add_ctrl.sv
// ============================================================================
// tb_cla_serial_add_ctrl : directed and random checks of the serial CLA adder
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_cla_serial_add_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int tests = 0;
  int fails = 0;

  cla_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef CLA_SERIAL_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Stimulus only: present operands until an accepting edge has passed.
  task automatic send(input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic ic, output bit ok);
    a = ia; b = ib; cin = ic; in_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if ({cout, sum} !== 17'h0) begin fails++; $display("FAIL reset_sum got %b/%h want 0/0000", cout, sum); end
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    bit ok;
    send(16'h00FF, 16'h0001, 1'b0, ok);
    tests++; if (!ok) begin fails++; $display("FAIL basic_accept timeout"); end
    tests++; if ({in_ready, busy} !== 2'b01) begin fails++; $display("FAIL basic_ready_busy got %b%b want 01", in_ready, busy); end
    repeat (3) @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0 || sum !== 16'h0000) begin fails++; $display("FAIL basic_early got v=%b sum=%h want v=0 sum=0000", out_valid, sum); end
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_latency got out_valid=%b want 1", out_valid); end
    tests++; if ({cout, sum} !== {1'b0, 16'h0100}) begin fails++; $display("FAIL basic_sum got %b/%h want 0/0100", cout, sum); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL basic_in_ready_done got %b want 0", in_ready); end
    handshake();
    tests++; if ({out_valid, in_ready, busy} !== 3'b010) begin fails++; $display("FAIL basic_release got v/r/b=%b%b%b want 010", out_valid, in_ready, busy); end
    tests++; if (sum !== 16'h0100) begin fails++; $display("FAIL basic_sum_hold got %h want 0100", sum); end
  endtask

  task automatic test_wrap();
    bit ok, ok2;
    send(16'hFFFF, 16'h0001, 1'b0, ok); wait_valid(ok2);
    tests++; if (!(ok && ok2) || {cout, sum} !== {1'b1, 16'h0000}) begin fails++; $display("FAIL wrap_plus1 got %b/%h want 1/0000", cout, sum); end
    handshake();
    send(16'hFFFF, 16'h0000, 1'b1, ok); wait_valid(ok2);
    tests++; if (!(ok && ok2) || {cout, sum} !== {1'b1, 16'h0000}) begin fails++; $display("FAIL wrap_cin got %b/%h want 1/0000", cout, sum); end
    handshake();
  endtask

  task automatic test_backpressure();
    bit ok, ok2;
    send(16'h1234, 16'h4321, 1'b0, ok); wait_valid(ok2);
    tests++; if (!(ok && ok2)) begin fails++; $display("FAIL bp_first timeout"); end
    a = 16'h8000; b = 16'h8000; cin = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if ({out_valid, in_ready, cout, sum} !== {3'b100, 16'h5555}) begin
        fails++; $display("FAIL bp_hold cyc=%0d got v=%b r=%b %b/%h want v=1 r=0 0/5555", i, out_valid, in_ready, cout, sum);
      end
      @(posedge clk); #1;
    end
    handshake();
    tests++; if ({out_valid, in_ready} !== 2'b01) begin fails++; $display("FAIL bp_no_bypass got v/r=%b%b want 01", out_valid, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests++; if ({in_ready, busy} !== 2'b01) begin fails++; $display("FAIL bp_accept_next got r/b=%b%b want 01", in_ready, busy); end
    wait_valid(ok);
    tests++; if (!ok || {cout, sum} !== {1'b1, 16'h0001}) begin fails++; $display("FAIL bp_second got %b/%h want 1/0001", cout, sum); end
    handshake();
  endtask

  task automatic test_reset_mid_run();
    bit ok, ok2;
    send(16'h1234, 16'h1111, 1'b1, ok);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({in_ready, out_valid, busy, cout, sum} !== {4'b1000, 16'h0000}) begin
      fails++; $display("FAIL midrun_reset got r/v/b=%b%b%b %b/%h want 100 0/0000", in_ready, out_valid, busy, cout, sum);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    send(16'h0F0F, 16'h0101, 1'b1, ok); wait_valid(ok2);
    tests++; if (!(ok && ok2) || {cout, sum} !== {1'b0, 16'h1011}) begin fails++; $display("FAIL midrun_after got %b/%h want 0/1011", cout, sum); end
    handshake();
  endtask

  task automatic test_back_to_back();
    bit ok, got;
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W:0]   exp;
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom_range(0, 1));
      exp = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      send(ra, rb, rc, ok);
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) begin
          got = 1'b1;
          tests++;
          if ({cout, sum} !== exp) begin fails++; $display("FAIL rand_sum n=%0d got %b/%h want %b/%h", n, cout, sum, exp[W], exp[W-1:0]); end
        end
        @(posedge clk); #1;
      end
      out_ready = 1'b0;
      tests++;
      if (!ok || !got || out_valid !== 1'b0) begin fails++; $display("FAIL rand_txn n=%0d got acc=%b done=%b v=%b want 1 1 0", n, ok, got, out_valid); end
    end
  endtask

`ifdef CLA_SERIAL_SUB_EN
  task automatic test_sub();
    bit ok, ok2;
    sub = 1'b1;
    send(16'h0005, 16'h0007, 1'b0, ok); wait_valid(ok2);
    tests++; if (!(ok && ok2) || {cout, sum} !== {1'b0, 16'hFFFE}) begin fails++; $display("FAIL sub_borrow got %b/%h want 0/fffe", cout, sum); end
    handshake();
    send(16'h0007, 16'h0005, 1'b0, ok); wait_valid(ok2);
    tests++; if (!(ok && ok2) || {cout, sum} !== {1'b1, 16'h0002}) begin fails++; $display("FAIL sub_noborrow got %b/%h want 1/0002", cout, sum); end
    handshake();
    sub = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_reset_mid_run();
`ifdef CLA_SERIAL_SUB_EN
    test_sub();
`endif
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
